// File: rtl/starsoc_params.sv
// Shared StarSoC video-path parameters, states and pixel bundle type.
package starsoc_params;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int DATA_W   = 24;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACTIVE,
        WAIT_EOL
    } rx_state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pix_beat_t;

    function automatic logic [15:0] rgb_sum(input logic [DATA_W-1:0] d);
        return 16'(d[23:16]) + 16'(d[15:8]) + 16'(d[7:0]);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic 2-entry valid/ready buffer; in_ready depends only on
// registered occupancy, so there is no ready path from output to input.
module axis_skid_buffer #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  T     in_data,
    input  logic in_valid,
    output logic in_ready,
    output T     out_data,
    output logic out_valid,
    input  logic out_ready
);

    logic [1:0] count;
    T           head;
    T           skid;
    logic       push;
    logic       pop;

    assign in_ready  = (count != 2'd2) & ~reset;
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            head  <= '0;
            skid  <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            unique case (count)
                2'd0: if (push) head <= in_data;
                2'd1: begin
                    if (push && pop)
                        head <= in_data;
                    else if (push)
                        skid <= in_data;
                end
                2'd2: if (pop) head <= skid;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axis_video_rx.sv
// AXI4-Stream video sink: SOF/EOL framing, x/y tagging, sticky errors.
// Optional per-frame checksum output under AXIS_VIDEO_RX_CHECKSUM_EN.
module axis_video_rx #(
    parameter int H_ACTIVE = starsoc_params::H_ACTIVE,
    parameter int V_ACTIVE = starsoc_params::V_ACTIVE,
    parameter int DATA_W   = starsoc_params::DATA_W,
    parameter int CNT_W    = 16
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tuser,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [DATA_W-1:0] pix_data,
    output logic [9:0]        pix_x,
    output logic [9:0]        pix_y,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_count,
    output logic              in_frame,
    output logic              err_sof_early,
    output logic              err_eol_early,
    output logic              err_eol_late,
    input  logic              err_clear
`ifdef AXIS_VIDEO_RX_CHECKSUM_EN
    ,
    output logic [15:0]       frame_sum
`endif
);

    import starsoc_params::*;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    rx_state_t  state, state_n;
    logic [9:0] x, y, x_n, y_n;
    logic       frame_err, ferr_n;
    logic       beat, fwd, sof, done_n;
    logic       set_sof, set_eoe, set_eol;
    pix_beat_t  beat_in, beat_out;

    assign beat     = s_tvalid & s_tready;
    assign in_frame = (state != WAIT_SOF);

    always_comb begin
        state_n       = state;
        x_n           = x;
        y_n           = y;
        ferr_n        = frame_err;
        fwd           = 1'b0;
        sof           = 1'b0;
        done_n        = 1'b0;
        set_sof       = 1'b0;
        set_eoe       = 1'b0;
        set_eol       = 1'b0;
        beat_in.data  = s_tdata;
        beat_in.x     = x;
        beat_in.y     = y;
        if (beat) begin
            if (s_tuser) begin
                // Any SOF restarts framing; mid-frame it aborts the frame.
                set_sof   = (state != WAIT_SOF) && ((x != '0) || (y != '0));
                sof       = 1'b1;
                fwd       = 1'b1;
                beat_in.x = '0;
                beat_in.y = '0;
                x_n       = 10'd1;
                y_n       = '0;
                ferr_n    = 1'b0;
                state_n   = ACTIVE;
            end else begin
                unique case (state)
                    ACTIVE: begin
                        fwd = 1'b1;
                        if (x == X_LAST) begin
                            if (!s_tlast) begin
                                set_eol = 1'b1;
                                ferr_n  = 1'b1;
                                state_n = WAIT_EOL;
                            end else if (y == Y_LAST) begin
                                x_n     = '0;
                                y_n     = '0;
                                done_n  = ~frame_err;
                                state_n = WAIT_SOF;
                            end else begin
                                x_n = '0;
                                y_n = y + 10'd1;
                            end
                        end else if (s_tlast) begin
                            set_eoe = 1'b1;
                            ferr_n  = 1'b1;
                            x_n     = '0;
                            if (y == Y_LAST) begin
                                y_n     = '0;
                                state_n = WAIT_SOF;
                            end else begin
                                y_n = y + 10'd1;
                            end
                        end else begin
                            x_n = x + 10'd1;
                        end
                    end
                    WAIT_EOL: begin
                        if (s_tlast) begin
                            x_n = '0;
                            if (y == Y_LAST) begin
                                y_n     = '0;
                                state_n = WAIT_SOF;
                            end else begin
                                y_n     = y + 10'd1;
                                state_n = ACTIVE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state         <= WAIT_SOF;
            x             <= '0;
            y             <= '0;
            frame_err     <= 1'b0;
            frame_done    <= 1'b0;
            frame_count   <= '0;
            err_sof_early <= 1'b0;
            err_eol_early <= 1'b0;
            err_eol_late  <= 1'b0;
        end else begin
            state       <= state_n;
            x           <= x_n;
            y           <= y_n;
            frame_err   <= ferr_n;
            frame_done  <= done_n;
            frame_count <= frame_count + CNT_W'(done_n);
            err_sof_early <= set_sof | (err_sof_early & ~err_clear);
            err_eol_early <= set_eoe | (err_eol_early & ~err_clear);
            err_eol_late  <= set_eol | (err_eol_late & ~err_clear);
        end
    end

`ifdef AXIS_VIDEO_RX_CHECKSUM_EN
    logic [15:0] sum_acc;
    logic [15:0] sum_add;

    assign sum_add = rgb_sum(s_tdata);

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else begin
            if (sof)
                sum_acc <= sum_add;
            else if (fwd)
                sum_acc <= sum_acc + sum_add;
            if (done_n)
                frame_sum <= sum_acc + sum_add;
        end
    end
`endif

    axis_skid_buffer #(
        .T (pix_beat_t)
    ) u_skid (
        .clk       (pixel_clk),
        .reset     (reset),
        .in_data   (beat_in),
        .in_valid  (fwd),
        .in_ready  (s_tready),
        .out_data  (beat_out),
        .out_valid (pix_valid),
        .out_ready (pix_ready)
    );

    assign pix_data = beat_out.data;
    assign pix_x    = beat_out.x;
    assign pix_y    = beat_out.y;

endmodule

// File: tb/tb_axis_video_rx.sv
// Randomized bench for axis_video_rx on a reduced 16x8 raster.
// Expected pixels come from the stimulus scenarios themselves.
module tb_axis_video_rx;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int CW = 2;

    logic          pixel_clk = 1'b0;
    logic          reset = 1'b1;
    logic [23:0]   s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tuser = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [23:0]   pix_data;
    logic [9:0]    pix_x;
    logic [9:0]    pix_y;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic          frame_done;
    logic [CW-1:0] frame_count;
    logic          in_frame;
    logic          err_sof_early;
    logic          err_eol_early;
    logic          err_eol_late;
    logic          err_clear = 1'b0;
`ifdef AXIS_VIDEO_RX_CHECKSUM_EN
    logic [15:0]   frame_sum;
`endif

    int          total = 0;
    int          bad = 0;
    logic [43:0] exp_q[$];
    int          n_in = 0;
    int          n_out = 0;
    int          n_done = 0;
    int          stall_pct = 0;
    int          gap_pct = 0;
    bit          const_pix = 1'b0;
    logic [15:0] fsum = '0;

    axis_video_rx #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .DATA_W   (24),
        .CNT_W    (CW)
    ) dut (
        .pixel_clk     (pixel_clk),
        .reset         (reset),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tuser       (s_tuser),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .pix_data      (pix_data),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .in_frame      (in_frame),
        .err_sof_early (err_sof_early),
        .err_eol_early (err_eol_early),
        .err_eol_late  (err_eol_late),
        .err_clear     (err_clear)
`ifdef AXIS_VIDEO_RX_CHECKSUM_EN
        ,
        .frame_sum     (frame_sum)
`endif
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: occupancy model, stall stability, in-order pixels.
    initial begin
        int          occ;
        bit          prev_stall;
        logic [43:0] prev_pix;
        prev_stall = 1'b0;
        prev_pix   = '0;
        forever begin
            @(negedge pixel_clk);
            pix_ready = ($urandom_range(0, 99) >= stall_pct);
            #2;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                occ = n_in - n_out;
                chk("tready_occ", s_tready, occ < 2);
                chk("pvalid_occ", pix_valid, occ > 0);
                if (prev_stall)
                    chk("stall_stable", {pix_data, pix_x, pix_y}, prev_pix);
                if (frame_done)
                    n_done++;
                if (pix_valid && pix_ready) begin
                    chk("pix_q", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0)
                        chk("pix", {pix_data, pix_x, pix_y}, exp_q.pop_front());
                    n_out++;
                end
                prev_stall = pix_valid && !pix_ready;
                prev_pix   = {pix_data, pix_x, pix_y};
            end
        end
    end

    task automatic send(input logic u, input logic l, input logic fwd,
                        input logic [9:0] ex, input logic [9:0] ey,
                        input logic clr);
        logic [23:0] d;
        bit          acc;
        int          tries;
        acc   = 1'b0;
        tries = 0;
        d     = const_pix ? 24'h010101 : 24'($urandom);
        while (!acc && tries < 2000) begin
            @(negedge pixel_clk);
            s_tdata   = d;
            s_tuser   = u;
            s_tlast   = l;
            s_tvalid  = 1'b1;
            err_clear = clr;
            #1 acc = s_tready;
            tries++;
        end
        chk("accept", acc, 1);
        if (!acc) begin
            s_tvalid = 1'b0;
            return;
        end
        @(posedge pixel_clk);
        if (fwd) begin
            if (u)
                fsum = '0;
            fsum = fsum + 16'(d[23:16]) + 16'(d[15:8]) + 16'(d[7:0]);
            exp_q.push_back({d, ex, ey});
            n_in++;
        end
    endtask

    task automatic gap();
        while ($urandom_range(0, 99) < gap_pct) begin
            @(negedge pixel_clk);
            s_tvalid  = 1'b0;
            err_clear = 1'b0;
        end
    endtask

    task automatic send_pix(input int i, input logic u);
        int px, py;
        px = i % H;
        py = i / H;
        gap();
        send(u, px == H - 1, 1'b1, 10'(px), 10'(py), 1'b0);
    endtask

    task automatic send_frame();
        for (int i = 0; i < H * V; i++)
            send_pix(i, i == 0);
    endtask

    task automatic drain();
        @(negedge pixel_clk);
        s_tvalid  = 1'b0;
        err_clear = 1'b0;
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++)
            @(negedge pixel_clk);
        repeat (3) @(negedge pixel_clk);
        #3;
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge pixel_clk);
        reset     = 1'b1;
        s_tvalid  = 1'b0;
        err_clear = 1'b0;
        exp_q.delete();
        n_in  = 0;
        n_out = 0;
        @(negedge pixel_clk);
        #1;
        chk("rst_tready", s_tready, 0);
        chk("rst_pvalid", pix_valid, 0);
        chk("rst_pix", {pix_data, pix_x, pix_y}, 0);
        chk("rst_status", {frame_done, frame_count, in_frame, err_sof_early,
                           err_eol_early, err_eol_late}, 0);
`ifdef AXIS_VIDEO_RX_CHECKSUM_EN
        chk("rst_sum", frame_sum, 0);
`endif
        @(negedge pixel_clk);
        reset = 1'b0;
        #1;
        chk("tready_after_rst", s_tready, 1);
        n_done = 0;
    endtask

    initial begin
        // clean frame, no backpressure
        do_reset();
        for (int i = 0; i < H * V; i++) begin
            send_pix(i, i == 0);
            if (i == H * V / 2) begin
                #1 chk("in_frame_mid", in_frame, 1);
            end
        end
        drain();
        chk("clean_done", n_done, 1);
        chk("clean_cnt", frame_count, 1);
        chk("clean_err", {err_sof_early, err_eol_early, err_eol_late}, 0);
        chk("clean_idle", in_frame, 0);
`ifdef AXIS_VIDEO_RX_CHECKSUM_EN
        chk("clean_sum", frame_sum, fsum);
`endif

        // beats before the first SOF are discarded
        do_reset();
        for (int i = 0; i < 5; i++)
            send(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);
        send_frame();
        drain();
        chk("pre_sof_done", n_done, 1);
        chk("pre_sof_cnt", frame_count, 1);

        // early EOL at x=10 of line 3, with err_clear on the same edge
        do_reset();
        for (int i = 0; i < 3 * H + 10; i++)
            send_pix(i, i == 0);
        send(1'b0, 1'b1, 1'b1, 10'd10, 10'd3, 1'b1);
        for (int i = 4 * H; i < H * V; i++)
            send_pix(i, 1'b0);
        drain();
        chk("eoe_flags", {err_sof_early, err_eol_early, err_eol_late}, 3'b010);
        chk("eoe_done", n_done, 0);
        chk("eoe_cnt", frame_count, 0);
        @(negedge pixel_clk);
        err_clear = 1'b1;
        @(negedge pixel_clk);
        err_clear = 1'b0;
        #1 chk("err_clear", {err_sof_early, err_eol_early, err_eol_late}, 0);

        // early SOF at (5,3), then the restarted frame completes
        do_reset();
        for (int i = 0; i < 3 * H + 5; i++)
            send_pix(i, i == 0);
        send_frame();
        drain();
        chk("sofe_flags", {err_sof_early, err_eol_early, err_eol_late}, 3'b100);
        chk("sofe_done", n_done, 1);
        chk("sofe_cnt", frame_count, 1);

        // missing EOL on line 2: extra beats dropped until tlast
        do_reset();
        for (int i = 0; i < 3 * H - 1; i++)
            send_pix(i, i == 0);
        send(1'b0, 1'b0, 1'b1, 10'(H - 1), 10'd2, 1'b0);
        #1 chk("wait_eol_in_frame", in_frame, 1);
        send(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        send(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        send(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 3 * H; i < H * V; i++)
            send_pix(i, 1'b0);
        drain();
        chk("eol_late_flags", {err_sof_early, err_eol_early, err_eol_late}, 3'b001);
        chk("eol_late_done", n_done, 0);
        chk("eol_late_cnt", frame_count, 0);

        // random backpressure and gaps, frame counter wraps
        do_reset();
        stall_pct = 30;
        gap_pct   = 20;
        for (int f = 0; f < 5; f++)
            send_frame();
        drain();
        chk("stall_done", n_done, 5);
        chk("wrap_cnt", frame_count, 5 % (1 << CW));
        chk("stall_err", {err_sof_early, err_eol_early, err_eol_late}, 0);

        // reset mid-line 5 with two pixels held in the buffer
        for (int i = 0; i < 5 * H + 6; i++)
            send_pix(i, i == 0);
        drain();
        stall_pct = 100;
        gap_pct   = 0;
        send_pix(5 * H + 6, 1'b0);
        send_pix(5 * H + 7, 1'b0);
        repeat (2) @(negedge pixel_clk);
        #3 chk("held_two", n_in - n_out, 2);
        do_reset();
        stall_pct = 0;
        const_pix = 1'b1;
        send(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        send(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        send_frame();
        drain();
        chk("post_rst_done", n_done, 1);
        chk("post_rst_cnt", frame_count, 1);
        chk("post_rst_err", {err_sof_early, err_eol_early, err_eol_late}, 0);
`ifdef AXIS_VIDEO_RX_CHECKSUM_EN
        chk("const_sum", frame_sum, (H * V * 3) % 65536);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
